// File: rtl/instr_issue_unit.sv
// Purpose: buffers RV32 instruction words and issues the Opcode/Funct field pair to top_control.
// Latency: a word written to an idle unit is issued one clock edge after its write. There is no bypass path.
// Backpressure: in_ready deasserts while the FIFO holds DEPTH words. Outputs hold stable while issue_ready=0.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous clear of FIFO and output stage (illegal_cnt is kept)
//   in_valid/in_ready   instruction input handshake, in_instr = 32-bit word
//   issue_valid/ready   output handshake for Opcode, Funct and illegal
//   count               FIFO occupancy, not counting the word in the output stage
//   illegal_cnt         saturating count of illegal instructions handed off
module instr_issue_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [6:0]        Opcode,
    output logic [3:0]        Funct,
    output logic              illegal,
    output logic [ADDR_W:0]   count,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_t state;
    state_t state_nxt;

    // Only the decoded fields are kept, as {instr[30], instr[14:12], instr[6:0]}.
    logic [10:0]       mem [DEPTH];
    logic [10:0]       in_fields;
    logic [10:0]       head;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              load;
    logic              handoff;
    logic              has_data;
    logic              head_illegal;
    logic              unused_instr_bits;

    assign in_fields         = {in_instr[30], in_instr[14:12], in_instr[6:0]};
    assign unused_instr_bits = ^{in_instr[31], in_instr[29:15], in_instr[11:7]};

    assign in_ready    = (count != FULL_CNT);
    assign has_data    = (count != '0);
    assign issue_valid = (state == ST_FULL);
    // A flush drops any word offered in the same cycle, even though in_ready may be 1.
    assign push        = in_valid && in_ready && !flush;
    assign head        = mem[rd_ptr];

    always_comb begin
        head_illegal = 1'b1;
        case (head[6:0])
            7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: head_illegal = 1'b0;
            default: head_illegal = 1'b1;
        endcase
    end

    // Output stage: load pops the FIFO head into the output registers.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        handoff   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (has_data) begin
                    load      = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (issue_ready) begin
                    handoff = 1'b1;
                    if (has_data) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // flush takes priority over pop and handoff.
        if (flush) begin
            state_nxt = ST_EMPTY;
            load      = 1'b0;
            handoff   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // The storage array has no reset. The pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, load};
        end
    end

    // Output registers keep their last value when the stage empties or is flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Opcode  <= '0;
            Funct   <= '0;
            illegal <= 1'b0;
        end else if (load) begin
            Opcode  <= head[6:0];
            Funct   <= head[10:7];
            illegal <= head_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (handoff && illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Purpose: self-checking bench for instr_issue_unit against a queue-based reference model.
// Latency: the model advances on each rising edge. Outputs are compared 1 time unit later.
// Backpressure: issue_ready is driven low, high and randomly to exercise FIFO fill and drain.
module tb_instr_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
    logic        illegal;
    logic [2:0]  count;
    logic [7:0]  illegal_cnt;

    int tests = 0;
    int fails = 0;

    instr_issue_unit #(.DEPTH(4), .ADDR_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .Opcode(Opcode), .Funct(Funct), .illegal(illegal),
        .count(count), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of buffered words plus a one-entry output holder.
    logic [31:0] mq[$];
    bit          m_vld;
    logic [6:0]  m_op;
    logic [3:0]  m_fn;
    bit          m_ill;
    int          m_cnt;

    localparam logic [24:0] RESET_VEC = {1'b0, 7'd0, 4'd0, 1'b0, 3'd0, 1'b1, 8'd0};

    wire [24:0] dut_vec = {issue_valid, Opcode, Funct, illegal, count, in_ready, illegal_cnt};

    function automatic bit is_illegal(logic [6:0] op);
        return !(op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_vld, m_op, m_fn, m_ill, 3'(mq.size()), (mq.size() != 4), 8'(m_cnt)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_vld = 0;
        m_op  = '0;
        m_fn  = '0;
        m_ill = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        bit          can_push;
        logic [31:0] w;
        if (flush) begin
            mq.delete();
            m_vld = 0;
        end else begin
            can_push = in_valid && (mq.size() < 4);
            if (m_vld && issue_ready && m_ill && m_cnt < 255) m_cnt++;
            if ((!m_vld || issue_ready) && mq.size() > 0) begin
                w     = mq.pop_front();
                m_vld = 1;
                m_op  = w[6:0];
                m_fn  = {w[30], w[14:12]};
                m_ill = is_illegal(w[6:0]);
            end else if (m_vld && issue_ready) begin
                m_vld = 0;
            end
            if (can_push) mq.push_back(in_instr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, RESET_VEC);
        end
        model_reset();
        rst_n = 1'b1;
        tick();
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL idle_after_reset: got %h expected %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_add_sub();
        issue_ready = 1'b1;
        in_valid    = 1'b1;
        in_instr    = 32'h0000_0033;
        tick();
        tests++;
        if (issue_valid !== 1'b0 || count !== 3'd1) begin
            fails++;
            $display("FAIL no_bypass: got valid=%b count=%0d expected valid=0 count=1", issue_valid, count);
        end
        in_instr = 32'h4000_0033;
        tick();
        in_valid = 1'b0;
        tests++;
        if ({issue_valid, Opcode, Funct, illegal} !== {1'b1, 7'b0110011, 4'b0000, 1'b0}) begin
            fails++;
            $display("FAIL add_issue: got v=%b op=%b fn=%b ill=%b expected v=1 op=0110011 fn=0000 ill=0",
                     issue_valid, Opcode, Funct, illegal);
        end
        tick();
        tests++;
        if ({issue_valid, Opcode, Funct, illegal} !== {1'b1, 7'b0110011, 4'b1000, 1'b0}) begin
            fails++;
            $display("FAIL sub_issue: got v=%b op=%b fn=%b ill=%b expected v=1 op=0110011 fn=1000 ill=0",
                     issue_valid, Opcode, Funct, illegal);
        end
        tick();
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL add_sub_drain: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_full_fifo();
        logic [31:0] words [5];
        logic [6:0]  ops   [4];
        words = '{32'h0000_F033, 32'h0000_E033, 32'h0000_2003, 32'h0000_2023, 32'h0000_0063};
        ops   = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011};
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL fill_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        tests++;
        if (in_ready !== 1'b0 || count !== 3'd4 || Funct !== 4'b0111) begin
            fails++;
            $display("FAIL full_stall: got rdy=%b count=%0d fn=%b expected rdy=0 count=4 fn=0111",
                     in_ready, count, Funct);
        end
        // Pop and push offered together while full: only the pop happens.
        in_instr    = 32'h0000_0033;
        issue_ready = 1'b1;
        tick();
        tests++;
        if (count !== 3'd3 || Funct !== 4'b0110) begin
            fails++;
            $display("FAIL full_pop_no_push: got count=%0d fn=%b expected count=3 fn=0110", count, Funct);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (count !== 3'd3 || Opcode !== ops[0]) begin
            fails++;
            $display("FAIL push_after_pop: got count=%0d op=%b expected count=3 op=%b", count, Opcode, ops[0]);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            tests++;
            if (Opcode !== ops[i] || issue_valid !== 1'b1) begin
                fails++;
                $display("FAIL drain_order_%0d: got op=%b v=%b expected op=%b v=1", i, Opcode, issue_valid, ops[i]);
            end
        end
        tick();
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL full_final: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_illegal_flush();
        issue_ready = 1'b1;
        in_valid    = 1'b1;
        in_instr    = 32'h0000_0013;
        tick();
        in_valid = 1'b0;
        tick();
        tests++;
        if (illegal !== 1'b1 || Opcode !== 7'b0010011 || illegal_cnt !== 8'd0) begin
            fails++;
            $display("FAIL illegal_flag: got ill=%b op=%b cnt=%0d expected ill=1 op=0010011 cnt=0",
                     illegal, Opcode, illegal_cnt);
        end
        tick();
        tests++;
        if (illegal_cnt !== 8'd1) begin
            fails++;
            $display("FAIL illegal_count: got %0d expected 1", illegal_cnt);
        end
        // Fill one output stage plus three FIFO entries with illegal words, then flush.
        issue_ready = 1'b0;
        in_valid    = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if (count !== 3'd3 || issue_valid !== 1'b1) begin
            fails++;
            $display("FAIL pre_flush: got count=%0d v=%b expected count=3 v=1", count, issue_valid);
        end
        flush       = 1'b1;
        issue_ready = 1'b1;
        in_instr    = 32'h0000_0033;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (count !== 3'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 8'd1) begin
            fails++;
            $display("FAIL flush: got count=%0d v=%b rdy=%b cnt=%0d expected count=0 v=0 rdy=1 cnt=1",
                     count, issue_valid, in_ready, illegal_cnt);
        end
        tick();
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL post_flush: got %h expected %h", dut_vec, exp_vec());
        end
        // Stream over 300 illegal handoffs so the counter reaches saturation.
        in_valid = 1'b1;
        in_instr = 32'h0000_0013;
        for (int i = 0; i < 310; i++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL sat_stream_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        tests++;
        if (illegal_cnt !== 8'd255) begin
            fails++;
            $display("FAIL illegal_saturate: got %0d expected 255", illegal_cnt);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b1;
        in_valid    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = {$urandom} & 32'hFFFF_FF80 | 32'h33;
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if (dut_vec !== RESET_VEC) begin
            fails++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, RESET_VEC);
        end
        model_reset();
        in_valid    = 1'b0;
        issue_ready = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_instr = 32'h4000_0033;
        tick();
        in_valid = 1'b0;
        tests++;
        if (issue_valid !== 1'b0 || count !== 3'd1) begin
            fails++;
            $display("FAIL reset_then_write: got v=%b count=%0d expected v=0 count=1", issue_valid, count);
        end
        tick();
        tests++;
        if (issue_valid !== 1'b1 || Funct !== 4'b1000 || count !== 3'd0 || illegal_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_first_issue: got v=%b fn=%b count=%0d cnt=%0d expected v=1 fn=1000 count=0 cnt=0",
                     issue_valid, Funct, count, illegal_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] op_pool [6];
        op_pool = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b1101111};
        for (int i = 0; i < 600; i++) begin
            flush       = ($urandom_range(0, 39) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            issue_ready = ($urandom_range(0, 9) < 6);
            in_instr    = {$urandom} & 32'hFFFF_FF80 | {25'd0, op_pool[$urandom_range(0, 5)]};
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_sub();
        test_full_fifo();
        test_illegal_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
